// File: rtl/dds_ctrl_mc_if.sv
// Encoder-to-DDS control bus: pulse inputs from the encoder decoder, per-channel
// wave/frequency outputs and the update strobe towards the phase accumulators.
interface dds_ctrl_mc_if #(
    parameter int CH_NUM = 2,
    parameter int FW     = 24
);
    localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    // Handshake: L/R/O are one-cycle strobes with no back-pressure, so every
    // asserted cycle is consumed. upd is a one-cycle strobe qualified by upd_ch;
    // upd_ch and accel hold between strobes.
    logic                   L_pulse;
    logic                   R_pulse;
    logic                   O_pulse;
    logic [1:0]             mode;
    logic [CW-1:0]          ch_sel;
    logic [2*CH_NUM-1:0]    wave_bus;
    logic [FW*CH_NUM-1:0]   f_inc_bus;
    logic                   upd;
    logic [CW-1:0]          upd_ch;
    logic                   accel;

    modport master (
        output L_pulse, R_pulse, O_pulse,
        input  mode, ch_sel, wave_bus, f_inc_bus, upd, upd_ch, accel
    );

    modport slave (
        input  L_pulse, R_pulse, O_pulse,
        output mode, ch_sel, wave_bus, f_inc_bus, upd, upd_ch, accel
    );
endinterface

// File: rtl/dds_ctrl_mc.sv
// Multi-channel DDS control: one rotary encoder walks channel / waveform /
// frequency via a three-state mode machine, with accelerated frequency steps.
module dds_ctrl_mc #(
    parameter int            CH_NUM    = 2,
    parameter int            FW        = 24,
    parameter logic [FW-1:0] F_MIN     = 24'h10000,
    parameter logic [FW-1:0] F_MAX     = 24'h140000,
    parameter logic [FW-1:0] F_RESET   = 24'hA0000,
    parameter logic [FW-1:0] STEP      = 24'h10000,
    parameter int            ACCEL_MUL = 8,
    parameter int            ACCEL_WIN = 1_200_000
) (
    input logic          clk,
    input logic          rst_n,
    dds_ctrl_mc_if.slave bus
);
    localparam int            CW        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int            GW        = $clog2(ACCEL_WIN + 1);
    localparam logic [GW-1:0] WIN       = GW'(ACCEL_WIN);
    localparam logic [FW-1:0] STEP_FAST = FW'(STEP * ACCEL_MUL);
    localparam logic [CW-1:0] CH_LAST   = CW'(CH_NUM - 1);

    typedef enum logic [1:0] {
        FREQ_ADJ = 2'b00,
        WAVE_SEL = 2'b01,
        CH_SEL   = 2'b10
    } mode_t;

    mode_t         mode_q;
    logic [CW-1:0] ch_q;
    logic [CW-1:0] upd_ch_q;
    logic [1:0]    wave_q [CH_NUM];
    logic [FW-1:0] f_q    [CH_NUM];
    logic          upd_q;
    logic          accel_q;
    logic          last_r_q;
    logic [GW-1:0] gap_q;

    logic          turn;
    logic          fast;
    logic [FW-1:0] step;
    logic [FW-1:0] f_cur;
    logic [FW:0]   f_sum;
    logic [FW:0]   f_diff;
    logic [FW-1:0] f_up;
    logic [FW-1:0] f_dn;
    logic [FW-1:0] f_nxt;

    // Sum and difference carry one extra bit so the clamp sees the true value.
    always_comb begin
        turn   = bus.L_pulse ^ bus.R_pulse;
        fast   = (gap_q < WIN) && (bus.R_pulse == last_r_q);
        step   = fast ? STEP_FAST : STEP;
        f_cur  = f_q[ch_q];
        f_sum  = {1'b0, f_cur} + {1'b0, step};
        f_diff = {1'b0, f_cur} - {1'b0, step};
        f_up   = (f_sum > {1'b0, F_MAX}) ? F_MAX : f_sum[FW-1:0];
        f_dn   = (f_diff[FW] || (f_diff < {1'b0, F_MIN})) ? F_MIN : f_diff[FW-1:0];
        f_nxt  = bus.R_pulse ? f_up : f_dn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= FREQ_ADJ;
            ch_q     <= '0;
            upd_ch_q <= '0;
            upd_q    <= 1'b0;
            accel_q  <= 1'b0;
            last_r_q <= 1'b1;
            gap_q    <= WIN;
            for (int k = 0; k < CH_NUM; k++) begin
                wave_q[k] <= 2'b00;
                f_q[k]    <= F_RESET;
            end
        end else begin
            upd_q <= 1'b0;
            if (gap_q != WIN) begin
                gap_q <= gap_q + 1'b1;
            end
            if (bus.O_pulse) begin
                case (mode_q)
                    FREQ_ADJ: begin
                        mode_q <= WAVE_SEL;
                        gap_q  <= WIN;
                    end
                    WAVE_SEL: mode_q <= CH_SEL;
                    default:  mode_q <= FREQ_ADJ;
                endcase
            end else if (turn) begin
                case (mode_q)
                    CH_SEL: begin
                        if (bus.R_pulse) begin
                            ch_q <= (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                        end else begin
                            ch_q <= (ch_q == '0) ? CH_LAST : ch_q - 1'b1;
                        end
                    end
                    WAVE_SEL: begin
                        wave_q[ch_q] <= bus.R_pulse ? wave_q[ch_q] + 2'd1 : wave_q[ch_q] - 2'd1;
                        upd_q        <= 1'b1;
                        upd_ch_q     <= ch_q;
                    end
                    default: begin
                        // A clamped step still restarts the gap window and latches direction.
                        if (f_nxt != f_cur) begin
                            f_q[ch_q] <= f_nxt;
                            upd_q     <= 1'b1;
                            upd_ch_q  <= ch_q;
                        end
                        gap_q    <= '0;
                        last_r_q <= bus.R_pulse;
                        accel_q  <= fast;
                    end
                endcase
            end
        end
    end

    assign bus.mode   = mode_q;
    assign bus.ch_sel = ch_q;
    assign bus.upd    = upd_q;
    assign bus.upd_ch = upd_ch_q;
    assign bus.accel  = accel_q;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_bus
        assign bus.wave_bus[2*k +: 2]   = wave_q[k];
        assign bus.f_inc_bus[FW*k +: FW] = f_q[k];
    end
endmodule

// File: tb/tb_dds_ctrl_mc.sv
// Bench for dds_ctrl_mc: a 4-channel and a 3-channel instance share the same
// encoder stimulus and are compared every cycle against a behavioural model.
module tb_dds_ctrl_mc;
    localparam int FW    = 24;
    localparam int WIN   = 16;
    localparam int F_MIN = 'h10000;
    localparam int F_MAX = 'h140000;
    localparam int F_RST = 'hA0000;
    localparam int STEP  = 'h10000;
    localparam int MUL   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dds_ctrl_mc_if #(.CH_NUM(4), .FW(FW)) if4 ();
    dds_ctrl_mc_if #(.CH_NUM(3), .FW(FW)) if3 ();

    dds_ctrl_mc #(.CH_NUM(4), .FW(FW), .ACCEL_WIN(WIN)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    dds_ctrl_mc #(.CH_NUM(3), .FW(FW), .ACCEL_WIN(WIN)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model, one slot per instance.
    int     m_n [2] = '{4, 3};
    int     m_mode [2];
    int     m_ch [2];
    int     m_upd [2];
    int     m_uch [2];
    int     m_acc [2];
    int     m_last_r [2];
    int     m_recent_ok [2];
    int     m_wave [2][8];
    int     m_f [2][8];
    longint m_cyc [2];
    longint m_last_cyc [2];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_ch[i] = 0; m_upd[i] = 0; m_uch[i] = 0; m_acc[i] = 0;
            m_last_r[i] = 1; m_recent_ok[i] = 0; m_cyc[i] = 0; m_last_cyc[i] = 0;
            for (int k = 0; k < 8; k++) begin
                m_wave[i][k] = 0;
                m_f[i][k]    = F_RST;
            end
        end
    endtask

    task automatic model_step(input int l, input int r, input int o);
        int is_fast, st, nf;
        for (int i = 0; i < 2; i++) begin
            m_cyc[i]++;
            m_upd[i] = 0;
            if (o != 0) begin
                if (m_mode[i] == 0) m_recent_ok[i] = 0;
                m_mode[i] = (m_mode[i] + 1) % 3;
            end else if (l != r) begin
                if (m_mode[i] == 2) begin
                    m_ch[i] = (m_ch[i] + ((r != 0) ? 1 : m_n[i] - 1)) % m_n[i];
                end else if (m_mode[i] == 1) begin
                    m_wave[i][m_ch[i]] = (m_wave[i][m_ch[i]] + ((r != 0) ? 1 : 3)) % 4;
                    m_upd[i] = 1;
                    m_uch[i] = m_ch[i];
                end else begin
                    // Fast when the previous accepted turn, in the same direction and
                    // without leaving FREQ_ADJ, came at most WIN cycles ago.
                    is_fast = (m_recent_ok[i] != 0 && (m_cyc[i] - m_last_cyc[i]) <= WIN &&
                               m_last_r[i] == r) ? 1 : 0;
                    st = (is_fast != 0) ? STEP * MUL : STEP;
                    nf = (r != 0) ? m_f[i][m_ch[i]] + st : m_f[i][m_ch[i]] - st;
                    if (nf > F_MAX) nf = F_MAX;
                    if (nf < F_MIN) nf = F_MIN;
                    if (nf != m_f[i][m_ch[i]]) begin
                        m_f[i][m_ch[i]] = nf;
                        m_upd[i] = 1;
                        m_uch[i] = m_ch[i];
                    end
                    m_recent_ok[i] = 1;
                    m_last_cyc[i]  = m_cyc[i];
                    m_last_r[i]    = r;
                    m_acc[i]       = is_fast;
                end
            end
        end
    endtask

    task automatic check_dut(input int i, input logic [1:0] mode, input logic [2:0] ch,
                             input logic [15:0] wv, input logic [191:0] fb, input logic upd,
                             input logic [2:0] uch, input logic acc);
        logic [191:0] exp_f;
        logic [15:0]  exp_w;
        exp_f = '0;
        exp_w = '0;
        for (int k = 0; k < m_n[i]; k++) begin
            exp_w[2*k +: 2]   = 2'(m_wave[i][k]);
            exp_f[FW*k +: FW] = FW'(m_f[i][k]);
        end
        chk($sformatf("d%0d.mode", i), 192'(mode), 192'(m_mode[i]));
        chk($sformatf("d%0d.ch_sel", i), 192'(ch), 192'(m_ch[i]));
        chk($sformatf("d%0d.wave_bus", i), 192'(wv), 192'(exp_w));
        chk($sformatf("d%0d.f_inc_bus", i), fb, exp_f);
        chk($sformatf("d%0d.upd", i), 192'(upd), 192'(m_upd[i]));
        chk($sformatf("d%0d.upd_ch", i), 192'(uch), 192'(m_uch[i]));
        chk($sformatf("d%0d.accel", i), 192'(acc), 192'(m_acc[i]));
    endtask

    task automatic check_all();
        check_dut(0, if4.mode, 3'(if4.ch_sel), 16'(if4.wave_bus), 192'(if4.f_inc_bus),
                  if4.upd, 3'(if4.upd_ch), if4.accel);
        check_dut(1, if3.mode, 3'(if3.ch_sel), 16'(if3.wave_bus), 192'(if3.f_inc_bus),
                  if3.upd, 3'(if3.upd_ch), if3.accel);
    endtask

    task automatic set_pulses(input int l, input int r, input int o);
        if4.L_pulse = (l != 0); if4.R_pulse = (r != 0); if4.O_pulse = (o != 0);
        if3.L_pulse = (l != 0); if3.R_pulse = (r != 0); if3.O_pulse = (o != 0);
    endtask

    // Called at a negedge: present pulses, let one edge sample them, check at the next negedge.
    task automatic step(input int l, input int r, input int o);
        set_pulses(l, r, o);
        @(posedge clk);
        model_step(l, r, o);
        @(negedge clk);
        set_pulses(0, 0, 0);
        check_all();
    endtask

    task automatic do_reset();
        set_pulses(0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        check_all();
        rst_n = 1'b1;
    endtask

    typedef struct {
        int idle; int l; int r; int o;
        int e_mode; int e_ch; int e_w0; int e_f0; int e_f1; int e_upd; int e_uch; int e_acc;
    } vec_t;

    vec_t tv [19];

    initial begin
        tv[0]  = '{0,  0, 1, 0, 0, 0, 0, 'hB0000,  'hA0000,  1, 0, 0};
        tv[1]  = '{4,  0, 1, 0, 0, 0, 0, 'h130000, 'hA0000,  1, 0, 1};
        tv[2]  = '{4,  1, 0, 0, 0, 0, 0, 'h120000, 'hA0000,  1, 0, 0};
        tv[3]  = '{20, 0, 1, 0, 0, 0, 0, 'h130000, 'hA0000,  1, 0, 0};
        tv[4]  = '{0,  1, 1, 0, 0, 0, 0, 'h130000, 'hA0000,  0, 0, 0};
        tv[5]  = '{0,  0, 1, 1, 1, 0, 0, 'h130000, 'hA0000,  0, 0, 0};
        tv[6]  = '{0,  1, 0, 0, 1, 0, 3, 'h130000, 'hA0000,  1, 0, 0};
        tv[7]  = '{0,  0, 0, 1, 2, 0, 3, 'h130000, 'hA0000,  0, 0, 0};
        tv[8]  = '{0,  0, 1, 0, 2, 1, 3, 'h130000, 'hA0000,  0, 0, 0};
        tv[9]  = '{0,  0, 0, 1, 0, 1, 3, 'h130000, 'hA0000,  0, 0, 0};
        tv[10] = '{0,  0, 1, 0, 0, 1, 3, 'h130000, 'hB0000,  1, 1, 0};
        tv[11] = '{0,  0, 1, 0, 0, 1, 3, 'h130000, 'h130000, 1, 1, 1};
        tv[12] = '{0,  0, 1, 0, 0, 1, 3, 'h130000, 'h140000, 1, 1, 1};
        tv[13] = '{0,  0, 1, 0, 0, 1, 3, 'h130000, 'h140000, 0, 1, 1};
        tv[14] = '{0,  0, 0, 1, 1, 1, 3, 'h130000, 'h140000, 0, 1, 1};
        tv[15] = '{0,  0, 0, 1, 2, 1, 3, 'h130000, 'h140000, 0, 1, 1};
        tv[16] = '{0,  1, 0, 0, 2, 0, 3, 'h130000, 'h140000, 0, 1, 1};
        tv[17] = '{0,  1, 0, 0, 2, 3, 3, 'h130000, 'h140000, 0, 1, 1};
        tv[18] = '{0,  0, 0, 1, 0, 3, 3, 'h130000, 'h140000, 0, 1, 1};

        set_pulses(0, 0, 0);
        @(negedge clk);
        do_reset();
        chk("reset.f_inc", 192'(if4.f_inc_bus), {96'h0, {4{24'hA0000}}});

        // Directed walk on the 4-channel instance.
        for (int i = 0; i < 19; i++) begin
            repeat (tv[i].idle) step(0, 0, 0);
            step(tv[i].l, tv[i].r, tv[i].o);
            chk($sformatf("tv%0d.mode", i), 192'(if4.mode), 192'(tv[i].e_mode));
            chk($sformatf("tv%0d.ch_sel", i), 192'(if4.ch_sel), 192'(tv[i].e_ch));
            chk($sformatf("tv%0d.wave0", i), 192'(if4.wave_bus[1:0]), 192'(tv[i].e_w0));
            chk($sformatf("tv%0d.f0", i), 192'(if4.f_inc_bus[23:0]), 192'(tv[i].e_f0));
            chk($sformatf("tv%0d.f1", i), 192'(if4.f_inc_bus[47:24]), 192'(tv[i].e_f1));
            chk($sformatf("tv%0d.upd", i), 192'(if4.upd), 192'(tv[i].e_upd));
            chk($sformatf("tv%0d.upd_ch", i), 192'(if4.upd_ch), 192'(tv[i].e_uch));
            chk($sformatf("tv%0d.accel", i), 192'(if4.accel), 192'(tv[i].e_acc));
        end

        // Low clamp on channel 3 with widely spaced base steps.
        for (int i = 0; i < 12; i++) begin
            repeat (19) step(0, 0, 0);
            step(1, 0, 0);
            chk($sformatf("lo%0d.f3", i), 192'(if4.f_inc_bus[95:72]),
                192'((F_RST - (i + 1) * STEP < F_MIN) ? F_MIN : F_RST - (i + 1) * STEP));
            chk($sformatf("lo%0d.upd", i), 192'(if4.upd), 192'((i < 9) ? 1 : 0));
        end
        // High clamp: twenty spaced R pulses from F_MIN.
        for (int i = 0; i < 20; i++) begin
            repeat (19) step(0, 0, 0);
            step(0, 1, 0);
            chk($sformatf("hi%0d.f3", i), 192'(if4.f_inc_bus[95:72]),
                192'((F_MIN + (i + 1) * STEP > F_MAX) ? F_MAX : F_MIN + (i + 1) * STEP));
            chk($sformatf("hi%0d.upd", i), 192'(if4.upd), 192'((i < 19) ? 1 : 0));
            chk($sformatf("hi%0d.accel", i), 192'(if4.accel), 192'(0));
        end

        // Asynchronous reset while an accelerated update is on the outputs.
        do_reset();
        step(0, 1, 0);
        repeat (4) step(0, 0, 0);
        step(0, 1, 0);
        chk("mid.pre_f0", 192'(if4.f_inc_bus[23:0]), 192'('h130000));
        chk("mid.pre_upd", 192'(if4.upd), 192'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid.async_f0", 192'(if4.f_inc_bus[23:0]), 192'(F_RST));
        chk("mid.async_upd", 192'(if4.upd), 192'(0));
        chk("mid.async_accel", 192'(if4.accel), 192'(0));
        @(negedge clk);
        do_reset();
        step(0, 1, 0);
        chk("post.f0", 192'(if4.f_inc_bus[23:0]), 192'('hB0000));
        chk("post.accel", 192'(if4.accel), 192'(0));

        // Random encoder traffic at three pulse densities.
        for (int ph = 0; ph < 3; ph++) begin
            int busy;
            busy = (ph == 0) ? 60 : (ph == 1) ? 25 : 8;
            for (int c = 0; c < 1500; c++) begin
                int v, kind;
                v = $urandom_range(0, 99);
                kind = $urandom_range(0, 9);
                if (v < busy) begin
                    case (kind)
                        0:       step(0, 0, 1);
                        1:       step(1, 0, 1);
                        2:       step(1, 1, 0);
                        3, 4, 5: step(0, 1, 0);
                        default: step(1, 0, 0);
                    endcase
                end else begin
                    step(0, 0, 0);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
